// File: rtl/mmu_data_xlate_pkg.sv
// Shared types and constants for the data-side address translation stage.
package mmu_data_xlate_pkg;

  typedef enum logic [3:0] {
    EXC_NONE = 4'd0,
    EXC_MOD  = 4'd1,
    EXC_TLBL = 4'd2,
    EXC_TLBS = 4'd3,
    EXC_ADEL = 4'd4,
    EXC_ADES = 4'd5
  } exc_code_t;

  // Values of vaddr[31:29] for the two unmapped kernel segments.
  localparam logic [2:0]  KSEG0         = 3'b100;
  localparam logic [2:0]  KSEG1         = 3'b101;
  localparam logic [31:0] UNMAPPED_MASK = 32'h1FFF_FFFF;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;

  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] badvaddr;
    exc_code_t   exc;
    logic        refill;
    logic        uncached;
    logic        store;
  } resp_t;

  // Size 3 is handled like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = low[0];
      default:   is_misaligned = (low != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mmu_seg_decode.sv
// Combinational segment decode: flags mapped segments and forms the
// physical address/cacheability for the unmapped kseg0/kseg1 windows.
module mmu_seg_decode
  import mmu_data_xlate_pkg::*;
(
  input  logic [31:0] vaddr,
  input  logic        kseg0_uncached,
  output logic        mapped,
  output logic        uncached,
  output logic [31:0] paddr
);

  always_comb begin
    mapped   = 1'b1;
    uncached = 1'b0;
    paddr    = vaddr & UNMAPPED_MASK;
    case (vaddr[31:29])
      KSEG0: begin
        mapped   = 1'b0;
        uncached = kseg0_uncached;
      end
      KSEG1: begin
        mapped   = 1'b0;
        uncached = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mmu_data_xlate.sv
// Data-side virtual-to-physical translation: one register stage between a
// valid/ready request port and a valid/ready response port.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; a producer holds its payload stable while valid is high and ready low.
module mmu_data_xlate
  import mmu_data_xlate_pkg::*;
#(
  parameter int unsigned TLBW_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        user_mode,
  input  logic        kseg0_uncached,
  input  logic        flush,
  input  logic        tlbwi,
  input  logic        tlbwr,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_valid,
  input  logic        tlb_dirty,
  input  logic        tlb_uncached,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_paddr,
  output logic        resp_uncached,
  output logic        resp_store,
  output logic [3:0]  resp_exc_code,
  output logic        resp_tlb_refill,
  output logic [31:0] resp_badvaddr
);

  localparam int HOLD_W = (TLBW_HOLD > 1) ? $clog2(TLBW_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TLBW_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              resp_valid_q, resp_valid_d;
  resp_t             resp_q, resp_d;

  logic        seg_mapped, seg_uncached;
  logic [31:0] seg_paddr;
  logic        accept;
  logic        addr_err;
  resp_t       new_resp;

  mmu_seg_decode u_seg_decode (
    .vaddr          (req_vaddr),
    .kseg0_uncached (kseg0_uncached),
    .mapped         (seg_mapped),
    .uncached       (seg_uncached),
    .paddr          (seg_paddr)
  );

  assign tlb_vaddr = req_vaddr;

  // Writes to the TLB are not visible to the lookup port right away, so new
  // requests are held off for the write cycle plus TLBW_HOLD more.
  assign req_ready = (!resp_valid_q || resp_ready) && !flush &&
                     (hold_cnt_q == '0) && !tlbwi && !tlbwr;
  assign accept    = req_valid && req_ready;
  assign addr_err  = is_misaligned(req_size, req_vaddr[1:0]) ||
                     (user_mode && req_vaddr[31]);

  always_comb begin
    new_resp          = '0;
    new_resp.badvaddr = req_vaddr;
    new_resp.store    = req_store;
    new_resp.paddr    = seg_mapped ? tlb_paddr : seg_paddr;
    new_resp.uncached = seg_mapped ? tlb_uncached : seg_uncached;
    new_resp.exc      = EXC_NONE;
    if (addr_err) begin
      new_resp.exc = req_store ? EXC_ADES : EXC_ADEL;
    end else if (seg_mapped && tlb_miss) begin
      new_resp.exc    = req_store ? EXC_TLBS : EXC_TLBL;
      new_resp.refill = 1'b1;
    end else if (seg_mapped && !tlb_valid) begin
      new_resp.exc = req_store ? EXC_TLBS : EXC_TLBL;
    end else if (seg_mapped && req_store && !tlb_dirty) begin
      new_resp.exc = EXC_MOD;
    end
    if (new_resp.exc != EXC_NONE) begin
      new_resp.paddr = '0;
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (tlbwi || tlbwr) begin
      hold_cnt_d = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  // Flush wins over accept and drain; accept during a drain replaces in place.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    if (flush) begin
      resp_valid_d = 1'b0;
    end else if (accept) begin
      resp_valid_d = 1'b1;
      resp_d       = new_resp;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
    end
  end

  assign resp_valid      = resp_valid_q;
  assign resp_paddr      = resp_q.paddr;
  assign resp_uncached   = resp_q.uncached;
  assign resp_store      = resp_q.store;
  assign resp_exc_code   = resp_q.exc;
  assign resp_tlb_refill = resp_q.refill;
  assign resp_badvaddr   = resp_q.badvaddr;

endmodule

// File: tb/tb_mmu_data_xlate.sv
// Bench for mmu_data_xlate: directed corner cases then random traffic,
// checked against an address-arithmetic reference model.
module tb_mmu_data_xlate;

  localparam int TLBW_HOLD = 1;
  localparam int EW        = 71;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic [1:0]  req_size;
  logic        user_mode, kseg0_uncached, flush, tlbwi, tlbwr;
  logic [31:0] tlb_vaddr, tlb_paddr;
  logic        tlb_miss, tlb_valid, tlb_dirty, tlb_uncached;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_paddr, resp_badvaddr;
  logic        resp_uncached, resp_store, resp_tlb_refill;
  logic [3:0]  resp_exc_code;

  mmu_data_xlate #(.TLBW_HOLD(TLBW_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_store(req_store), .req_size(req_size), .user_mode(user_mode),
    .kseg0_uncached(kseg0_uncached), .flush(flush), .tlbwi(tlbwi), .tlbwr(tlbwr),
    .tlb_vaddr(tlb_vaddr), .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss),
    .tlb_valid(tlb_valid), .tlb_dirty(tlb_dirty), .tlb_uncached(tlb_uncached),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
    .resp_uncached(resp_uncached), .resp_store(resp_store),
    .resp_exc_code(resp_exc_code), .resp_tlb_refill(resp_tlb_refill),
    .resp_badvaddr(resp_badvaddr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          last_w = -100;

  // scoreboard: at most one pending response, packed as
  // {paddr, badvaddr, exc[3:0], refill, uncached, store}
  logic [EW-1:0] exp_q[$];

  // stimulus fields for the next step
  logic        s_valid, s_store, s_user, s_k0u, s_flush, s_wi, s_wr, s_rr;
  logic [31:0] s_vaddr, s_tpa;
  logic [1:0]  s_size;
  logic        s_tm, s_tv, s_td, s_tu;

  // last sampled DUT outputs
  logic        obs_ready, obs_valid, obs_unc, obs_refill;
  logic [31:0] obs_paddr, obs_bad;
  logic [3:0]  obs_exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] ref_resp(
    input logic [31:0] a, input logic st, input logic [1:0] sz, input logic um,
    input logic k0u, input logic [31:0] tpa, input logic tm, input logic tv,
    input logic td, input logic tu);
    int unsigned ua, seg, align, exc;
    logic        mapped, unc, refill;
    logic [31:0] pa;
    ua     = a;
    seg    = ua / 32'h2000_0000;
    align  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mapped = (seg != 4) && (seg != 5);
    pa     = mapped ? tpa : (ua % 32'h2000_0000);
    unc    = mapped ? tu : ((seg == 5) ? 1'b1 : k0u);
    exc    = 0;
    refill = 1'b0;
    if ((ua % align) != 0 || (um && seg >= 4)) exc = st ? 5 : 4;
    else if (mapped && tm) begin exc = st ? 3 : 2; refill = 1'b1; end
    else if (mapped && !tv) exc = st ? 3 : 2;
    else if (mapped && st && !td) exc = 1;
    if (exc != 0) pa = 32'h0;
    return {pa, a, exc[3:0], refill, unc, st};
  endfunction

  task automatic clear_stim();
    s_valid = 1'b0; s_vaddr = 32'h0; s_store = 1'b0; s_size = 2'd2;
    s_user = 1'b0; s_k0u = 1'b0; s_flush = 1'b0; s_wi = 1'b0; s_wr = 1'b0;
    s_rr = 1'b1; s_tpa = 32'h0; s_tm = 1'b0; s_tv = 1'b1; s_td = 1'b1; s_tu = 1'b0;
  endtask

  task automatic apply_idle();
    req_valid = 1'b0; req_vaddr = 32'h0; req_store = 1'b0; req_size = 2'd0;
    user_mode = 1'b0; kseg0_uncached = 1'b0; flush = 1'b0; tlbwi = 1'b0;
    tlbwr = 1'b0; resp_ready = 1'b0; tlb_paddr = 32'h0; tlb_miss = 1'b0;
    tlb_valid = 1'b0; tlb_dirty = 1'b0; tlb_uncached = 1'b0;
  endtask

  // driver: one clock cycle of stimulus, output checks, then model update
  task automatic step();
    logic          exp_ready;
    logic [EW-1:0] e;
    @(negedge clk);
    req_valid = s_valid; req_vaddr = s_vaddr; req_store = s_store; req_size = s_size;
    user_mode = s_user; kseg0_uncached = s_k0u; flush = s_flush; tlbwi = s_wi;
    tlbwr = s_wr; resp_ready = s_rr; tlb_paddr = s_tpa; tlb_miss = s_tm;
    tlb_valid = s_tv; tlb_dirty = s_td; tlb_uncached = s_tu;
    #1;
    obs_ready = req_ready; obs_valid = resp_valid; obs_paddr = resp_paddr;
    obs_bad = resp_badvaddr; obs_exc = resp_exc_code; obs_unc = resp_uncached;
    obs_refill = resp_tlb_refill;
    exp_ready = (exp_q.size() == 0 || s_rr) && !s_flush && !s_wi && !s_wr &&
                (cyc - last_w > TLBW_HOLD);
    check("tlb_vaddr", tlb_vaddr, s_vaddr);
    check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("resp_paddr", resp_paddr, e[70:39]);
      check("resp_badvaddr", resp_badvaddr, e[38:7]);
      check("resp_exc_code", {28'b0, resp_exc_code}, {28'b0, e[6:3]});
      check("resp_tlb_refill", {31'b0, resp_tlb_refill}, {31'b0, e[2]});
      check("resp_uncached", {31'b0, resp_uncached}, {31'b0, e[1]});
      check("resp_store", {31'b0, resp_store}, {31'b0, e[0]});
    end
    if (s_wi || s_wr) last_w = cyc;
    if (s_flush) begin
      exp_q.delete();
    end else if (s_valid && exp_ready) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(ref_resp(s_vaddr, s_store, s_size, s_user, s_k0u,
                               s_tpa, s_tm, s_tv, s_td, s_tu));
    end else if (s_rr && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    cyc++;
  endtask

  task automatic rand_stim();
    logic [31:0] low;
    low = $urandom;
    if ($urandom_range(0, 3) != 0) low[1:0] = 2'b00;
    s_valid = ($urandom_range(0, 3) != 0);
    s_vaddr = {3'($urandom_range(0, 7)), low[28:0]};
    s_store = 1'($urandom_range(0, 1));
    s_size  = 2'($urandom_range(0, 3));
    s_user  = ($urandom_range(0, 3) == 0);
    s_k0u   = 1'($urandom_range(0, 1));
    s_flush = ($urandom_range(0, 15) == 0);
    s_wi    = ($urandom_range(0, 24) == 0);
    s_wr    = ($urandom_range(0, 24) == 0);
    s_rr    = ($urandom_range(0, 3) != 0);
    s_tpa   = $urandom;
    s_tm    = ($urandom_range(0, 5) == 0);
    s_tv    = ($urandom_range(0, 5) != 0);
    s_td    = ($urandom_range(0, 3) != 0);
    s_tu    = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'h0);
    check({tag, "_exc"}, {28'b0, resp_exc_code}, 32'h0);
    check({tag, "_refill"}, {31'b0, resp_tlb_refill}, 32'h0);
    check({tag, "_paddr"}, resp_paddr, 32'h0);
    check({tag, "_badvaddr"}, resp_badvaddr, 32'h0);
    check({tag, "_uncached"}, {31'b0, resp_uncached}, 32'h0);
    check({tag, "_store"}, {31'b0, resp_store}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    apply_idle();
    clear_stim();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #2 rst = 1'b1;

    // load word in kseg0, cached
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h8000_1000; s_size = 2'd2;
    step();
    // store half, misaligned
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h0040_0001; s_size = 2'd1; s_store = 1'b1;
    step();
    check("k0_paddr", obs_paddr, 32'h0000_1000);
    check("k0_unc", {31'b0, obs_unc}, 32'h0);
    check("k0_exc", {28'b0, obs_exc}, 32'h0);
    // mapped load, TLB miss
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h0040_0000; s_tm = 1'b1;
    step();
    check("ades_exc", {28'b0, obs_exc}, 32'd5);
    check("ades_bad", obs_bad, 32'h0040_0001);
    check("ades_paddr", obs_paddr, 32'h0);
    // mapped load, invalid entry
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h0040_0000; s_tv = 1'b0;
    step();
    check("miss_exc", {28'b0, obs_exc}, 32'd2);
    check("miss_refill", {31'b0, obs_refill}, 32'h1);
    // mapped store, clean page
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h0040_0000; s_store = 1'b1; s_td = 1'b0;
    step();
    check("inv_exc", {28'b0, obs_exc}, 32'd2);
    check("inv_refill", {31'b0, obs_refill}, 32'h0);
    clear_stim();
    step();
    check("mod_exc", {28'b0, obs_exc}, 32'd1);

    // TLB write hazard hold
    clear_stim(); s_wi = 1'b1; s_valid = 1'b1; s_vaddr = 32'hA000_0000;
    step();
    check("hold_n0", {31'b0, obs_ready}, 32'h0);
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'hA000_0004;
    step();
    check("hold_n1", {31'b0, obs_ready}, 32'h0);
    step();
    check("hold_n2", {31'b0, obs_ready}, 32'h1);

    // back-pressure then flush with a request
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h8000_2000;
    step();
    for (int i = 0; i < 3; i++) begin
      clear_stim(); s_valid = 1'b1; s_vaddr = 32'h8000_3000 + 32'(i * 4); s_rr = 1'b0;
      step();
      check("stall_paddr", obs_paddr, 32'h0000_2000);
      check("stall_ready", {31'b0, obs_ready}, 32'h0);
    end
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h8000_4000; s_flush = 1'b1; s_rr = 1'b0;
    step();
    clear_stim();
    step();
    check("flush_valid", {31'b0, obs_valid}, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      rand_stim();
      step();
    end

    // reset in the middle of a transaction
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'h8000_5000; s_rr = 1'b0;
    step();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    apply_idle();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    last_w = cyc - 100;
    clear_stim(); s_valid = 1'b1; s_vaddr = 32'hA000_0100;
    step();
    check("post_rst_ready", {31'b0, obs_ready}, 32'h1);
    clear_stim();
    step();
    check("post_rst_paddr", obs_paddr, 32'h0000_0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
